// File: rtl/cache_responder_pkg.sv
// Shared definitions for the cache responder: controller state encoding,
// line geometry and the address-split width constants used by both the
// controller and its tag/valid/data array.
package cache_responder_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = 2;               // word offset within a line
  localparam int BYTE_W     = 2;               // byte-in-word bits, ignored
  localparam int BLK_W      = OFF_W + BYTE_W;  // index field starts here

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/cache_responder_array.sv
// Tag, valid and data storage for the direct-mapped cache responder.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset (valid bits only)
//   rd_idx, rd_off            combinational read port: line index and word offset
//   rd_valid, rd_tag, rd_word line valid bit, stored tag and addressed word
//   wr_idx, wr_off            write port address
//   wr_en, wr_word            word write at (wr_idx, wr_off)
//   line_we, line_valid,      line-state write at wr_idx: sets valid to line_valid,
//   line_tag                  and stores line_tag when the line becomes valid
module cache_responder_array
  import cache_responder_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = ADDR_W - BLK_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_word,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_word,
  input  logic              line_we,
  input  logic              line_valid,
  input  logic [TAG_W-1:0]  line_tag
);

  logic [DATA_W-1:0] data_mem [LINES*LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;

  assign rd_word  = data_mem[{rd_idx, rd_off}];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (line_we) valid_d[wr_idx] = line_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Storage contents need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_idx, wr_off}] <= wr_word;
    if (line_we && line_valid) tag_mem[wr_idx] <= line_tag;
  end

endmodule

// File: rtl/cache_responder.sv
// Direct-mapped, write-through / no-allocate cache responder.
// Loads that hit return data the cycle after acceptance; load misses fill
// the whole line from backing memory one word at a time; every store is
// written through to backing memory.
// Ports:
//   sys_clk_i, sys_rst_i          clock, asynchronous active-high reset
//   precycle_addr/enable/we,      CPU request (byte address, strobe, store flag)
//   cpu_wdata                     store data
//   cpu_rdata                     load data, held until the next load completes
//   cache_busy                    high while a fill or write-through is pending
//   mem_req/we/addr/wdata         backing-memory word request
//   mem_rdata, mem_ack            backing-memory response (transfer when req & ack)
module cache_responder #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = cache_responder_pkg::LINE_WORDS
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic [31:0] precycle_addr,
  input  logic        precycle_enable,
  input  logic        precycle_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cache_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  import cache_responder_pkg::*;

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - BLK_W - IDX_W;
  localparam int WA_W  = ADDR_W - BYTE_W;                 // word-address width
  localparam logic [OFF_W-1:0] K_LAST = OFF_W'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [OFF_W-1:0]  k_q, k_d, k_nxt;
  logic [WA_W-1:0]   req_q, req_d;   // word address of the request in flight

  logic [OFF_W-1:0]  cpu_off, req_off, rd_off, wr_off;
  logic [IDX_W-1:0]  cpu_idx, req_idx, rd_idx, wr_idx;
  logic [TAG_W-1:0]  cpu_tag, req_tag, rd_tag;
  logic              rd_valid, wr_en, line_we, line_valid;
  logic [31:0]       rd_word, wr_word;
  logic              in_idle, accept, hit, xfer;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^precycle_addr[BYTE_W-1:0];

  assign cpu_off = precycle_addr[BLK_W-1:BYTE_W];
  assign cpu_idx = precycle_addr[BLK_W +: IDX_W];
  assign cpu_tag = precycle_addr[ADDR_W-1 -: TAG_W];
  assign req_off = req_q[OFF_W-1:0];
  assign req_idx = req_q[OFF_W +: IDX_W];
  assign req_tag = req_q[WA_W-1 -: TAG_W];

  // The read port looks at the CPU address while idle (hit check, load data)
  // and at the latched request during a fill (to return the requested word).
  assign in_idle = (state_q == IDLE);
  assign rd_idx  = in_idle ? cpu_idx : req_idx;
  assign rd_off  = in_idle ? cpu_off : req_off;

  // busy_q is still high on the edge where it falls, so no accept can coincide.
  assign accept = precycle_enable && !busy_q && in_idle;
  assign hit    = rd_valid && (rd_tag == cpu_tag);
  assign xfer   = mem_req_q && mem_ack;
  assign k_nxt  = k_q + 1'b1;

  cache_responder_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (sys_clk_i),
    .rst        (sys_rst_i),
    .rd_idx     (rd_idx),
    .rd_off     (rd_off),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_word    (rd_word),
    .wr_idx     (wr_idx),
    .wr_off     (wr_off),
    .wr_en      (wr_en),
    .wr_word    (wr_word),
    .line_we    (line_we),
    .line_valid (line_valid),
    .line_tag   (req_tag)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    k_d         = k_q;
    req_d       = req_q;
    wr_en       = 1'b0;
    wr_idx      = req_idx;
    wr_off      = k_q;
    wr_word     = mem_rdata;
    line_we     = 1'b0;
    line_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = precycle_addr[ADDR_W-1:BYTE_W];
          if (precycle_we) begin
            // Write-through, no-allocate: only a hitting line is updated.
            if (hit) begin
              wr_en   = 1'b1;
              wr_idx  = cpu_idx;
              wr_off  = cpu_off;
              wr_word = cpu_wdata;
            end
            state_d     = WRITE;
            busy_d      = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {precycle_addr[ADDR_W-1:BYTE_W], {BYTE_W{1'b0}}};
            mem_wdata_d = cpu_wdata;
          end else if (hit) begin
            cpu_rdata_d = rd_word;
          end else begin
            // Invalidate up front so an interrupted fill never leaves a
            // half-written line looking valid under its old tag.
            line_we    = 1'b1;
            line_valid = 1'b0;
            wr_idx     = cpu_idx;
            state_d    = FILL;
            busy_d     = 1'b1;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            k_d        = '0;
            mem_addr_d = {precycle_addr[ADDR_W-1:BLK_W], {BLK_W{1'b0}}};
          end
        end
      end

      FILL: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (k_q == K_LAST) begin
            line_we     = 1'b1;
            line_valid  = 1'b1;
            // Earlier words are already in the array; the last one is only on the bus.
            cpu_rdata_d = (req_off == k_q) ? mem_rdata : rd_word;
            state_d     = IDLE;
            busy_d      = 1'b0;
            mem_req_d   = 1'b0;
            k_d         = '0;
          end else begin
            k_d        = k_nxt;
            mem_addr_d = {req_q[WA_W-1:OFF_W], k_nxt, {BYTE_W{1'b0}}};
          end
        end
      end

      WRITE: begin
        if (xfer) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      k_q         <= '0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      k_q         <= k_d;
      req_q       <= req_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cache_busy = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cache_responder.sv
// Directed bench for cache_responder: a backing-memory responder process
// checks every bus transfer against a queue of expected transactions, while
// the main sequence drives CPU requests and checks CPU-side results.
module tb_cache_responder;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i;
  logic [31:0] precycle_addr, cpu_wdata, cpu_rdata;
  logic        precycle_enable, precycle_we, cache_busy;
  logic        mem_req, mem_we, mem_ack, mem_ack_m, spur_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  assign mem_ack = mem_ack_m | spur_ack;

  always #5 sys_clk_i = ~sys_clk_i;

  cache_responder #(.LINES(16)) dut (
    .sys_clk_i       (sys_clk_i),
    .sys_rst_i       (sys_rst_i),
    .precycle_addr   (precycle_addr),
    .precycle_enable (precycle_enable),
    .precycle_we     (precycle_we),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cache_busy      (cache_busy),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xact_t;

  xact_t       exp_q[$];
  logic [31:0] bmem [logic [31:0]];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          xfer_cnt = 0;
  int          ack_dly  = 1;

  // Backing memory contents for never-written words.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a < 32'h200) return 32'hA0 + {30'd0, a[3:2]};
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] d);
    precycle_addr   = a;
    precycle_we     = we;
    cpu_wdata       = d;
    precycle_enable = 1'b1;
    tick();
    precycle_enable = 1'b0;
  endtask

  task automatic push_x(input logic we, input logic [31:0] a, input logic [31:0] d);
    xact_t x;
    x.we    = we;
    x.addr  = a;
    x.wdata = d;
    exp_q.push_back(x);
  endtask

  task automatic push_fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) push_x(1'b0, base + 32'(4 * i), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (cache_busy && n < 100) begin
      tick();
      n++;
    end
    #1;
    check(tag, {31'd0, cache_busy}, 32'd0);
  endtask

  // Backing-memory responder: acks each request ack_dly cycles after it is seen.
  initial begin
    xact_t e;
    mem_ack_m = 1'b0;
    mem_rdata = '0;
    tick();
    forever begin
      if (mem_req && !sys_rst_i) begin
        for (int i = 1; i < ack_dly; i++) tick();
        if (mem_req && !sys_rst_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL mem_unexpected: observed request addr 0x%08h, expected none", mem_addr);
          end else begin
            e = exp_q.pop_front();
            check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            check("mem_addr", mem_addr, e.addr);
            if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          end
          mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : dflt(mem_addr);
          if (mem_we) bmem[mem_addr] = mem_wdata;
          mem_ack_m = 1'b1;
          tick();
          mem_ack_m = 1'b0;
          xfer_cnt++;
        end
      end else begin
        tick();
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, observed %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int cnt;
    sys_rst_i       = 1'b1;
    precycle_addr   = '0;
    precycle_enable = 1'b0;
    precycle_we     = 1'b0;
    cpu_wdata       = '0;
    spur_ack        = 1'b0;
    tick();
    tick();
    check("rst_busy",      {31'd0, cache_busy}, 32'd0);
    check("rst_mem_req",   {31'd0, mem_req},    32'd0);
    check("rst_mem_we",    {31'd0, mem_we},     32'd0);
    check("rst_cpu_rdata", cpu_rdata,           32'd0);
    check("rst_mem_addr",  mem_addr,            32'd0);
    check("rst_mem_wdata", mem_wdata,           32'd0);
    sys_rst_i = 1'b0;
    tick();

    // Load miss 0x104: four-word fill of 0x100..0x10C, requested word 0xA1.
    ack_dly = 1;
    push_fill(32'h100);
    base = xfer_cnt;
    issue(32'h104, 1'b0, 32'd0);
    check("fill1_busy_t1", {31'd0, cache_busy}, 32'd1);
    wait_idle("fill1_idle");
    check("fill1_rdata", cpu_rdata, 32'hA1);
    check("fill1_xfers", xfer_cnt - base, 32'd4);
    check("fill1_q_empty", exp_q.size(), 32'd0);

    // Load hit 0x10C: data next cycle, no memory traffic.
    base = xfer_cnt;
    issue(32'h10C, 1'b0, 32'd0);
    check("hit_rdata", cpu_rdata, 32'hA3);
    check("hit_busy", {31'd0, cache_busy}, 32'd0);
    check("hit_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("hit_no_xfer", xfer_cnt - base, 32'd0);

    // Store hit 0x108, ack after 3 cycles.
    ack_dly = 3;
    push_x(1'b1, 32'h108, 32'hDEADBEEF);
    issue(32'h108, 1'b1, 32'hDEADBEEF);
    check("st_mem_addr", mem_addr, 32'h108);
    check("st_mem_we", {31'd0, mem_we}, 32'd1);
    cnt = 0;
    while (cache_busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check("st_busy_cycles", cnt, 32'd3);
    base = xfer_cnt;
    issue(32'h108, 1'b0, 32'd0);
    check("st_hit_rdata", cpu_rdata, 32'hDEADBEEF);
    check("st_hit_busy", {31'd0, cache_busy}, 32'd0);
    check("st_hit_no_req", {31'd0, mem_req}, 32'd0);

    // Store miss 0x208: one write, array untouched, so the load then fills.
    ack_dly = 1;
    tick();
    base = xfer_cnt;
    push_x(1'b1, 32'h208, 32'h55550208);
    issue(32'h208, 1'b1, 32'h55550208);
    wait_idle("stmiss_idle");
    check("stmiss_xfers", xfer_cnt - base, 32'd1);
    tick();
    base = xfer_cnt;
    push_fill(32'h200);
    issue(32'h208, 1'b0, 32'd0);
    check("ldmiss_busy", {31'd0, cache_busy}, 32'd1);
    wait_idle("ldmiss_idle");
    check("ldmiss_rdata", cpu_rdata, 32'h55550208);
    check("ldmiss_xfers", xfer_cnt - base, 32'd4);
    check("ldmiss_q_empty", exp_q.size(), 32'd0);

    // Request held during a fill is ignored until busy reads 0, then accepted once.
    ack_dly = 2;
    tick();
    push_fill(32'h410);
    base = xfer_cnt;
    issue(32'h414, 1'b0, 32'd0);
    precycle_addr   = 32'h208;
    precycle_enable = 1'b1;
    cnt = 0;
    while (cache_busy && cnt < 100) begin
      cnt++;
      tick();
    end
    check("hold_rdata_at_fall", cpu_rdata, 32'hC0DE0414);
    #1;
    check("hold_fill_xfers", xfer_cnt - base, 32'd4);
    tick();
    precycle_enable = 1'b0;
    check("hold_accept_rdata", cpu_rdata, 32'h55550208);
    check("hold_accept_busy", {31'd0, cache_busy}, 32'd0);
    check("hold_accept_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("rdata_holds", cpu_rdata, 32'h55550208);

    // mem_ack without mem_req has no effect.
    spur_ack = 1'b1;
    tick();
    tick();
    spur_ack = 1'b0;
    check("spur_busy", {31'd0, cache_busy}, 32'd0);
    check("spur_req", {31'd0, mem_req}, 32'd0);
    check("spur_rdata", cpu_rdata, 32'h55550208);

    // Reset after the 2nd fill ack of 0x300 abandons the fill.
    ack_dly = 2;
    push_fill(32'h300);
    base = xfer_cnt;
    issue(32'h300, 1'b0, 32'd0);
    cnt = 0;
    while ((xfer_cnt - base) < 2 && cnt < 50) begin
      @(posedge sys_clk_i);
      #2;
      cnt++;
    end
    check("rst_fill_wait", xfer_cnt - base, 32'd2);
    sys_rst_i = 1'b1;
    #1;
    check("rstfill_req", {31'd0, mem_req}, 32'd0);
    check("rstfill_busy", {31'd0, cache_busy}, 32'd0);
    check("rstfill_rdata", cpu_rdata, 32'd0);
    check("rstfill_addr", mem_addr, 32'd0);
    exp_q.delete();
    tick();
    tick();
    sys_rst_i = 1'b0;
    tick();
    push_fill(32'h300);
    base = xfer_cnt;
    issue(32'h300, 1'b0, 32'd0);
    check("refill_busy", {31'd0, cache_busy}, 32'd1);
    wait_idle("refill_idle");
    check("refill_rdata", cpu_rdata, 32'hC0DE0300);
    check("refill_xfers", xfer_cnt - base, 32'd4);
    check("refill_q_empty", exp_q.size(), 32'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
